// File: rtl/spi_pkt_pkg.sv
// Shared frame layout, constants and FSM state type for the sensor packet SPI master.
package spi_pkt_pkg;

  localparam int unsigned PACKET_SIZE = 16;
  localparam int unsigned FRAME_BITS  = PACKET_SIZE * 8;
  localparam logic [7:0]  HEADER_BYTE = 8'hAA;
  localparam logic [3:0]  LAST_BYTE   = 4'(PACKET_SIZE - 1);

  localparam int unsigned IDX_HEADER = 0;
  localparam int unsigned IDX_ROLL   = 1;
  localparam int unsigned IDX_PITCH  = 3;
  localparam int unsigned IDX_YAW    = 5;
  localparam int unsigned IDX_GYRO_X = 7;
  localparam int unsigned IDX_GYRO_Y = 9;
  localparam int unsigned IDX_GYRO_Z = 11;
  localparam int unsigned IDX_FLAGS  = 13;
  localparam int unsigned IDX_RSVD   = 14;
  localparam int unsigned IDX_CSUM   = 15;

  // LSB offsets inside the packed frame; byte 0 occupies the top 8 bits so it shifts out first.
  localparam int unsigned HEADER_LSB = FRAME_BITS - 8 * (IDX_HEADER + 1);
  localparam int unsigned ROLL_LSB   = FRAME_BITS - 8 * (IDX_ROLL + 2);
  localparam int unsigned PITCH_LSB  = FRAME_BITS - 8 * (IDX_PITCH + 2);
  localparam int unsigned YAW_LSB    = FRAME_BITS - 8 * (IDX_YAW + 2);
  localparam int unsigned GYRO_X_LSB = FRAME_BITS - 8 * (IDX_GYRO_X + 2);
  localparam int unsigned GYRO_Y_LSB = FRAME_BITS - 8 * (IDX_GYRO_Y + 2);
  localparam int unsigned GYRO_Z_LSB = FRAME_BITS - 8 * (IDX_GYRO_Z + 2);
  localparam int unsigned FLAGS_LSB  = FRAME_BITS - 8 * (IDX_FLAGS + 1);
  localparam int unsigned RSVD_LSB   = FRAME_BITS - 8 * (IDX_RSVD + 1);
  localparam int unsigned CSUM_LSB   = FRAME_BITS - 8 * (IDX_CSUM + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  function automatic logic [7:0] fold16(input logic [15:0] v);
    return v[15:8] ^ v[7:0];
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: while enabled, emits a rise or fall strobe every CLK_DIV clk cycles, starting low.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q;
  logic       phase_q;
  logic       tick;

  assign tick   = en_i && (div_q == DIV_LAST);
  assign rise_o = tick && !phase_q;
  assign fall_o = tick && phase_q;

  always_ff @(posedge clk) begin
    if (!rst_n || !en_i) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else if (tick) begin
      div_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

endmodule

// File: rtl/sensor_packet_spi_master.sv
// Latches a 16-byte sensor frame on start and shifts it out as an SPI Mode 0 master.
// Define SPI_PKT_CHECKSUM_EN to place the XOR of bytes 0..14 in byte 15.
module sensor_packet_spi_master
  import spi_pkt_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] roll,
  input  logic [15:0] pitch,
  input  logic [15:0] yaw,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  input  logic [7:0]  flags,
  output logic        cs_n,
  output logic        sck,
  output logic        sdo,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e                  state_q;
  logic [FRAME_BITS-1:0]   frame_q;
  logic [FRAME_BITS-1:0]   frame_d;
  logic [15:0]             cnt_q;
  logic [2:0]              bit_q;
  logic [3:0]              byte_q;
  logic [6:0]              next_idx;
  logic                    cs_n_q;
  logic                    sck_q;
  logic                    sdo_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    sck_rise;
  logic                    sck_fall;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == ST_SHIFT),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  always_comb begin
    frame_d = '0;
    frame_d[HEADER_LSB +: 8]  = HEADER_BYTE;
    frame_d[ROLL_LSB   +: 16] = roll;
    frame_d[PITCH_LSB  +: 16] = pitch;
    frame_d[YAW_LSB    +: 16] = yaw;
    frame_d[GYRO_X_LSB +: 16] = gyro_x;
    frame_d[GYRO_Y_LSB +: 16] = gyro_y;
    frame_d[GYRO_Z_LSB +: 16] = gyro_z;
    frame_d[FLAGS_LSB  +: 8]  = flags;
    frame_d[RSVD_LSB   +: 8]  = 8'h00;
`ifdef SPI_PKT_CHECKSUM_EN
    frame_d[CSUM_LSB +: 8] = HEADER_BYTE ^ fold16(roll) ^ fold16(pitch) ^ fold16(yaw)
                           ^ fold16(gyro_x) ^ fold16(gyro_y) ^ fold16(gyro_z) ^ flags;
`else
    frame_d[CSUM_LSB +: 8] = 8'h00;
`endif
  end

  // {byte,bit} is the serial bit number; its complement is the frame bit position.
  assign next_idx = {byte_q, bit_q} + 7'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            frame_q <= frame_d;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            sdo_q   <= frame_d[FRAME_BITS-1];
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            sck_q <= 1'b1;
          end
          if (sck_fall) begin
            sck_q <= 1'b0;
            if (byte_q == LAST_BYTE && bit_q == 3'd7) begin
              bit_q   <= '0;
              byte_q  <= '0;
              state_q <= ST_HOLD;
            end else begin
              bit_q  <= bit_q + 3'd1;
              byte_q <= (bit_q == 3'd7) ? byte_q + 4'd1 : byte_q;
              sdo_q  <= frame_q[~next_idx];
            end
          end
        end
        ST_HOLD: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            sdo_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cs_n = cs_n_q;
  assign sck  = sck_q;
  assign sdo  = sdo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sensor_packet_spi_master.sv
// Bench for sensor_packet_spi_master: SPI slave decoder, protocol monitor and byte-level frame model.
module tb_sensor_packet_spi_master;

  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 8;
  localparam int LOW_LEN    = (2 + 256) * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] roll = '0, pitch = '0, yaw = '0;
  logic [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
  logic [7:0]  flags = '0;
  logic        cs_n, sck, sdo, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  sensor_packet_spi_master #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .roll   (roll),
    .pitch  (pitch),
    .yaw    (yaw),
    .gyro_x (gyro_x),
    .gyro_y (gyro_y),
    .gyro_z (gyro_z),
    .flags  (flags),
    .cs_n   (cs_n),
    .sck    (sck),
    .sdo    (sdo),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Slave decoder and protocol monitor, sampling on the falling clk edge.
  logic [127:0] rx_q[$];
  int           rise_q[$];
  int           low_q[$];
  int           gap_q[$];
  logic [127:0] sh = '0;
  int rises = 0, rise_total = 0, low_len = 0, high_len = 0;
  int done_cnt = 0, win_cnt = 0, viol = 0;
  logic p_sck = 1'b0, p_sdo = 1'b0, p_cs = 1'b1, p_done = 1'b0;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (cs_n === 1'b0) begin
        if (p_cs) begin
          gap_q.push_back(high_len);
          win_cnt++;
          sh = '0;
          rises = 0;
          low_len = 0;
        end
        low_len++;
        if (sck === 1'b1 && p_sck === 1'b0) begin
          sh = {sh[126:0], sdo};
          rises++;
          rise_total++;
        end
      end else begin
        if (!p_cs) begin
          rx_q.push_back(sh);
          rise_q.push_back(rises);
          low_q.push_back(low_len);
          high_len = 0;
        end
        high_len++;
        if (sck !== 1'b0 || sdo !== 1'b0) viol++;
      end
      if (sck === 1'b1 && sdo !== p_sdo) viol++;
      if (done === 1'b1) begin
        done_cnt++;
        if (p_done) viol++;
      end
      p_sck  = sck;
      p_sdo  = sdo;
      p_cs   = cs_n;
      p_done = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_frame(input logic [15:0] r, p, y, gx, gy, gz,
                                               input logic [7:0] f);
    logic [7:0]   b[16];
    logic [15:0]  w[6];
    logic [127:0] o;
    w[0] = r; w[1] = p; w[2] = y; w[3] = gx; w[4] = gy; w[5] = gz;
    b[0] = 8'hAA;
    for (int k = 0; k < 6; k++) begin
      b[1 + 2 * k] = w[k][15:8];
      b[2 + 2 * k] = w[k][7:0];
    end
    b[13] = f;
    b[14] = 8'h00;
    b[15] = 8'h00;
`ifdef SPI_PKT_CHECKSUM_EN
    for (int k = 0; k < 15; k++) b[15] = b[15] ^ b[k];
`endif
    o = '0;
    for (int k = 0; k < 16; k++) o = {o[119:0], b[k]};
    return o;
  endfunction

  function automatic logic [127:0] cur_model();
    return model_frame(roll, pitch, yaw, gyro_x, gyro_y, gyro_z, flags);
  endfunction

  task automatic rand_payload();
    roll   = 16'($urandom);
    pitch  = 16'($urandom);
    yaw    = 16'($urandom);
    gyro_x = 16'($urandom);
    gyro_y = 16'($urandom);
    gyro_z = 16'($urandom);
    flags  = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4 * LOW_LEN; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    if (done !== 1'b1) check({tag, " done timeout"}, 128'(done), 128'd1);
  endtask

  task automatic check_packet(input string tag, input logic [127:0] exp);
    if (rx_q.size() == 0) begin
      check({tag, " packet present"}, 128'(rx_q.size()), 128'd1);
      return;
    end
    check({tag, " frame"}, rx_q.pop_front(), exp);
    check({tag, " rises"}, 128'(rise_q.pop_front()), 128'd128);
    check({tag, " cs_n low len"}, 128'(low_q.pop_front()), 128'(LOW_LEN));
  endtask

  task automatic send_packet(input string tag, input logic change_after);
    logic [127:0] exp;
    int d0, blen;
    exp = cur_model();
    d0  = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (change_after) begin
      roll   = roll ^ 16'($urandom_range(1, 65535));
      gyro_z = gyro_z ^ 16'($urandom_range(1, 65535));
      flags  = flags ^ 8'($urandom_range(1, 255));
    end
    check({tag, " busy at setup"}, 128'(busy), 128'd1);
    check({tag, " cs_n at setup"}, 128'(cs_n), 128'd0);
    check({tag, " sdo first bit"}, 128'(sdo), 128'(exp[127]));
    wait_done(tag);
    blen = 0;
    for (int i = 0; i < 4 * GAP_CYCLES + 8; i++) begin
      if (busy !== 1'b1) break;
      blen++;
      @(negedge clk);
    end
    check({tag, " busy after done"}, 128'(blen), 128'(GAP_CYCLES));
    @(negedge clk);
    check_packet(tag, exp);
    check({tag, " done pulses"}, 128'(done_cnt - d0), 128'd1);
  endtask

  initial begin
    logic [127:0] exp;
    logic [127:0] got;
    int d0, w0, rt0;

    repeat (3) @(negedge clk);
    check("reset cs_n", 128'(cs_n), 128'd1);
    check("reset sck", 128'(sck), 128'd0);
    check("reset sdo", 128'(sdo), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset done", 128'(done), 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed reference vector
    roll = 16'h1234; pitch = 16'hFFCE; yaw = 16'h0000;
    gyro_x = 16'h0001; gyro_y = 16'h8000; gyro_z = 16'h7FFF; flags = 8'h5A;
    exp = {120'hAA_1234_FFCE_0000_0001_8000_7FFF_5A_00, 8'h00};
`ifdef SPI_PKT_CHECKSUM_EN
    exp[7:0] = 8'hE6;
`endif
    check("model vs vector", cur_model(), exp);
    send_packet("vector", 1'b0);

    // Payload changes right after the latch cycle must not leak into the frame
    rand_payload();
    send_packet("late change", 1'b1);

    for (int n = 0; n < 4; n++) begin
      rand_payload();
      send_packet("random", 1'b0);
    end

    // start during GAP is dropped
    rand_payload();
    exp = cur_model();
    w0 = win_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("gap start");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    check("gap start windows", 128'(win_cnt - w0), 128'd1);
    check("gap start cs_n idle", 128'(cs_n), 128'd1);
    check_packet("gap start", exp);

    // start held high: back-to-back packets
    rand_payload();
    exp = cur_model();
    d0 = done_cnt;
    w0 = win_cnt;
    gap_q.delete();
    @(negedge clk); start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      wait_done("b2b");
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("b2b windows", 128'(win_cnt - w0), 128'd3);
    check("b2b done pulses", 128'(done_cnt - d0), 128'd3);
    check("b2b gap count", 128'(gap_q.size()), 128'd3);
    if (gap_q.size() == 3) begin
      check("b2b gap 1", 128'(gap_q[1] >= GAP_CYCLES), 128'd1);
      check("b2b gap 2", 128'(gap_q[2] >= GAP_CYCLES), 128'd1);
    end
    for (int n = 0; n < 3; n++) check_packet("b2b", exp);

    // Reset after the 40th rising sck edge
    rand_payload();
    d0  = done_cnt;
    rt0 = rise_total;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4 * LOW_LEN; i++) begin
      @(negedge clk);
      if (rise_total - rt0 >= 40) break;
    end
    check("abort reached edge 40", 128'(rise_total - rt0 >= 40), 128'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort cs_n", 128'(cs_n), 128'd1);
    check("abort sck", 128'(sck), 128'd0);
    check("abort busy", 128'(busy), 128'd0);
    check("abort done", 128'(done), 128'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort no done pulse", 128'(done_cnt - d0), 128'd0);
    check("abort record", 128'(rx_q.size()), 128'd1);
    if (rx_q.size() != 0) begin
      got = rx_q.pop_front();
      check("abort rises", 128'(rise_q.pop_front()), 128'd40);
      void'(low_q.pop_front());
    end
    rand_payload();
    send_packet("after reset", 1'b0);

    check("protocol violations", 128'(viol), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
